// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache bridge: line refills and write-backs from a single-port word RAM.
// Optional build macro MEM_RESP_STALL_EN inserts LFSR-driven bubbles into RAM bursts.
module cache_mem_responder #(
  parameter int MEM_AW   = 16,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_req,
  input  logic [2:0]        rd_type,
  input  logic [31:0]       rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output logic              ret_last,
  output logic [31:0]       ret_data,
  input  logic              wr_req,
  input  logic [2:0]        wr_type,
  input  logic [31:0]       wr_addr,
  input  logic [3:0]        wr_wstrb,
  input  logic [127:0]      wr_data,
  output logic              wr_rdy,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_BURST, S_WR_BURST} state_e;

  localparam logic [2:0] TYPE_LINE = 3'b100;
  localparam logic [3:0] WAIT_LD   = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [MEM_AW-1:0]   waddr_q, waddr_d;
  logic                line_q, line_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [127:0]        wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [3:0]          wait_q, wait_d;
  logic                ret_valid_q, ret_valid_d;
  logic                ret_last_q, ret_last_d;

  logic                stall;
  logic [2:0]          nbeats;
  logic                last_beat;
  logic                rd_issue;
  logic                wr_issue;
  logic                wr_acc;
  logic                rd_acc;
  logic                unused_ok;

`ifdef MEM_RESP_STALL_EN
  logic [3:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 4'b1111;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Address bits outside the RAM window alias; byte offsets are implied by the strobes.
  assign unused_ok = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0], wr_addr[31:MEM_AW+2], wr_addr[1:0]};

  assign nbeats    = line_q ? 3'd4 : 3'd1;
  assign last_beat = (cnt_q == nbeats - 3'd1);
  assign rd_issue  = (state_q == S_RD_BURST) && (cnt_q != nbeats) && !stall;
  assign wr_issue  = (state_q == S_WR_BURST) && !stall;
  assign wr_acc    = (state_q == S_IDLE) && wr_req;
  assign rd_acc    = (state_q == S_IDLE) && !wr_req && rd_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (wr_req)      state_d = S_WR_BURST;
        else if (rd_req) state_d = (WAIT_CYC > 0) ? S_RD_WAIT : S_RD_BURST;
      end
      S_RD_WAIT:  if (wait_q == 4'd0) state_d = S_RD_BURST;
      S_RD_BURST: if (ret_last_q) state_d = S_IDLE;
      S_WR_BURST: if (wr_issue && last_beat) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_rdy    = (state_q == S_IDLE) && !wr_req;
    wr_rdy    = (state_q == S_IDLE);
    mem_en    = rd_issue || wr_issue;
    mem_we    = wr_issue ? (line_q ? 4'hf : wstrb_q) : 4'h0;
    mem_addr  = line_q ? {waddr_q[MEM_AW-1:2], cnt_q[1:0]} : waddr_q;
    mem_wdata = wdata_q[{cnt_q[1:0], 5'b0} +: 32];
    ret_valid = ret_valid_q;
    ret_last  = ret_last_q;
    ret_data  = mem_rdata;
  end

  always_comb begin
    waddr_d     = waddr_q;
    line_d      = line_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    ret_valid_d = rd_issue;
    ret_last_d  = rd_issue && last_beat;
    if (wr_acc) begin
      waddr_d = wr_addr[MEM_AW+1:2];
      line_d  = (wr_type == TYPE_LINE);
      wstrb_d = wr_wstrb;
      wdata_d = wr_data;
      cnt_d   = 3'd0;
    end else if (rd_acc) begin
      waddr_d = rd_addr[MEM_AW+1:2];
      line_d  = (rd_type == TYPE_LINE);
      cnt_d   = 3'd0;
      wait_d  = WAIT_LD;
    end else begin
      if (rd_issue || wr_issue) cnt_d = cnt_q + 3'd1;
      if ((state_q == S_RD_WAIT) && (wait_q != 4'd0)) wait_d = wait_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      waddr_q     <= '0;
      line_q      <= 1'b0;
      wstrb_q     <= 4'h0;
      wdata_q     <= '0;
      cnt_q       <= 3'd0;
      wait_q      <= 4'd0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      line_q      <= line_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed refill/write-back cases, random line reads against an array model,
// and a WAIT_CYC=3 instance used for wait timing and mid-burst reset.
module tb_cache_mem_responder;

  logic         clk;
  logic         resetn, resetn_w;

  logic         rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy, mem_en;
  logic [2:0]   rd_type, wr_type;
  logic [31:0]  rd_addr, wr_addr, ret_data, mem_wdata, mem_rdata;
  logic [3:0]   wr_wstrb, mem_we;
  logic [127:0] wr_data;
  logic [15:0]  mem_addr;

  logic         rd_req_w, rd_rdy_w, ret_valid_w, ret_last_w, wr_req_w, wr_rdy_w, mem_en_w;
  logic [2:0]   rd_type_w, wr_type_w;
  logic [31:0]  rd_addr_w, wr_addr_w, ret_data_w, mem_wdata_w, mem_rdata_w;
  logic [3:0]   wr_wstrb_w, mem_we_w;
  logic [127:0] wr_data_w;
  logic [7:0]   mem_addr_w;

  logic [31:0]  ram  [0:65535];
  logic [31:0]  gold [0:65535];

  int n_assert = 0;
  int n_fail   = 0;

  cache_mem_responder #(.MEM_AW(16), .WAIT_CYC(0)) u_dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  cache_mem_responder #(.MEM_AW(8), .WAIT_CYC(3)) u_dut_w3 (
    .clk(clk), .resetn(resetn_w),
    .rd_req(rd_req_w), .rd_type(rd_type_w), .rd_addr(rd_addr_w), .rd_rdy(rd_rdy_w),
    .ret_valid(ret_valid_w), .ret_last(ret_last_w), .ret_data(ret_data_w),
    .wr_req(wr_req_w), .wr_type(wr_type_w), .wr_addr(wr_addr_w), .wr_wstrb(wr_wstrb_w),
    .wr_data(wr_data_w), .wr_rdy(wr_rdy_w),
    .mem_en(mem_en_w), .mem_we(mem_we_w), .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w),
    .mem_rdata(mem_rdata_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int unsigned i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a, input bit line, input int k, input int aw);
    int unsigned m;
    m = 32'd1 << aw;
    if (line) return ((((a >> 4) << 2) + k) % m);
    return ((a >> 2) % m);
  endfunction

  function automatic logic [2:0] nl_type();
    logic [2:0] t;
    t = 3'($urandom_range(0, 7));
    if (t == 3'b100) t = 3'b011;
    return t;
  endfunction

  // Synchronous word RAMs behind the two responders.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_en_w && (mem_we_w == 4'h0)) mem_rdata_w <= pat(32'(mem_addr_w));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input bit line, input logic [3:0] strb,
                             input logic [127:0] d);
    logic [31:0] w;
    if (line) begin
      for (int k = 0; k < 4; k++) gold[widx(a, 1, k, 16)] = d[32*k +: 32];
    end else begin
      w = gold[widx(a, 0, 0, 16)];
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
      gold[widx(a, 0, 0, 16)] = w;
    end
  endtask

  task automatic collect_read(input logic [31:0] a, input bit line, input string tag,
                              output logic [31:0] last_data);
    int nb, got, lasts, first_n, last_n;
    nb = line ? 4 : 1;
    got = 0; lasts = 0; first_n = -1; last_n = -1;
    last_data = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      rd_req = 1'b0;
      if (ret_valid === 1'b1) begin
        if (got < nb)
          chk($sformatf("%s data%0d", tag, got), ret_data, gold[widx(a, line, got, 16)]);
        if (got == 0) first_n = n;
        got++;
        if (ret_last === 1'b1) begin
          lasts++;
          last_n = n;
          last_data = ret_data;
          break;
        end
      end
    end
    chk({tag, " beats"}, 32'(got), 32'(nb));
    chk({tag, " last_count"}, 32'(lasts), 32'd1);
`ifndef MEM_RESP_STALL_EN
    chk({tag, " first_cycle"}, 32'(first_n), 32'd2);
    chk({tag, " last_cycle"}, 32'(last_n), 32'(1 + nb));
`endif
  endtask

  task automatic do_read(input logic [31:0] a, input bit line, input string tag,
                         output logic [31:0] last_data);
    @(negedge clk);
    rd_req  = 1'b1;
    rd_type = line ? 3'b100 : nl_type();
    rd_addr = a;
    #1 chk({tag, " rd_rdy"}, 32'(rd_rdy), 32'd1);
    @(posedge clk);
    collect_read(a, line, tag, last_data);
  endtask

  task automatic do_write(input logic [31:0] a, input bit line, input logic [3:0] strb,
                          input logic [127:0] d, input string tag);
    int nw, idle_n;
    nw = line ? 4 : 1;
    idle_n = -1;
    @(negedge clk);
    wr_req   = 1'b1;
    wr_type  = line ? 3'b100 : nl_type();
    wr_addr  = a;
    wr_wstrb = strb;
    wr_data  = d;
    #1 chk({tag, " wr_rdy"}, 32'(wr_rdy), 32'd1);
    @(posedge clk);
    model_write(a, line, strb, d);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      wr_req = 1'b0;
      #1;
      if (wr_rdy === 1'b1) begin
        idle_n = n;
        break;
      end
      chk({tag, " rd_rdy_busy"}, 32'(rd_rdy), 32'd0);
`ifndef MEM_RESP_STALL_EN
      if (n == 1) begin
        chk({tag, " mem_we"}, 32'(mem_we), line ? 32'hf : 32'(strb));
        chk({tag, " mem_addr"}, 32'(mem_addr), widx(a, line, 0, 16));
        chk({tag, " mem_wdata"}, mem_wdata, d[31:0]);
      end
`endif
    end
`ifndef MEM_RESP_STALL_EN
    chk({tag, " idle_cycle"}, 32'(idle_n), 32'(nw + 1));
`else
    chk({tag, " idle_seen"}, 32'(idle_n > 0), 32'd1);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0]  ld;
    logic [31:0]  a;
    logic [127:0] d;
    int           beats, first_n, rdy_n;

    resetn = 1'b0; resetn_w = 1'b0;
    rd_req = 1'b0; rd_type = 3'b0; rd_addr = '0;
    wr_req = 1'b0; wr_type = 3'b0; wr_addr = '0; wr_wstrb = 4'h0; wr_data = '0;
    rd_req_w = 1'b0; rd_type_w = 3'b0; rd_addr_w = '0;
    wr_req_w = 1'b0; wr_type_w = 3'b0; wr_addr_w = '0; wr_wstrb_w = 4'h0; wr_data_w = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = pat(32'(i));
      gold[i] = pat(32'(i));
    end
    for (int k = 0; k < 4; k++) begin
      ram[16'h40 + k]  = 32'hA0A0_0000 + 32'(k);
      gold[16'h40 + k] = 32'hA0A0_0000 + 32'(k);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("rst ret_valid", 32'(ret_valid), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    resetn = 1'b1; resetn_w = 1'b1;
    #1;
    chk("rst ret_last", 32'(ret_last), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst rd_rdy", 32'(rd_rdy), 32'd1);
    chk("rst wr_rdy", 32'(wr_rdy), 32'd1);

    do_read(32'h100, 1'b1, "line_0x100", ld);

    d = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    do_write(32'h200, 1'b1, 4'hf, d, "wline_0x200");
    do_read(32'h200, 1'b1, "rline_0x200", ld);

    do_write(32'h104, 1'b0, 4'hf, {96'b0, 32'h1122_3344}, "wsingle_full");
    do_write(32'h104, 1'b0, 4'b0011, {96'b0, 32'hAABB_CCDD}, "wsingle_strb");
    do_read(32'h104, 1'b0, "rsingle_0x104", ld);
    chk("single merge value", ld, 32'h1122_CCDD);

    // Same-cycle request tie: the write goes first, the read waits and sees its data.
    @(negedge clk);
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h300; wr_wstrb = 4'hf; wr_data = d;
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h300;
    #1;
    chk("tie wr_rdy", 32'(wr_rdy), 32'd1);
    chk("tie rd_rdy", 32'(rd_rdy), 32'd0);
    @(posedge clk);
    model_write(32'h300, 1'b1, 4'hf, d);
    rdy_n = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      wr_req = 1'b0;
      #1;
      if (rd_rdy === 1'b1) begin
        rdy_n = n;
        break;
      end
    end
`ifndef MEM_RESP_STALL_EN
    chk("tie rd_rdy_cycle", 32'(rdy_n), 32'd5);
`else
    chk("tie rd_rdy_seen", 32'(rdy_n > 0), 32'd1);
`endif
    if (rdy_n > 0) begin
      @(posedge clk);
      collect_read(32'h300, 1'b1, "tie_read", ld);
    end else begin
      rd_req = 1'b0;
    end

    for (int i = 0; i < 100; i++) begin
      a = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        do_write(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d, $sformatf("rw%0d", i));
        if ($urandom_range(0, 1) == 1) a = $urandom();
      end
      if ($urandom_range(0, 3) == 0)
        do_read($urandom(), 1'b0, $sformatf("rs%0d", i), ld);
      do_read(a, 1'b1, $sformatf("rl%0d", i), ld);
    end

    // WAIT_CYC=3 instance: first beat timing, then reset on the second beat.
    @(negedge clk);
    rd_req_w = 1'b1; rd_type_w = 3'b100; rd_addr_w = 32'h0000_0030;
    #1 chk("w3 rd_rdy", 32'(rd_rdy_w), 32'd1);
    @(posedge clk);
    beats = 0; first_n = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      rd_req_w = 1'b0;
      if (ret_valid_w === 1'b1) begin
        chk($sformatf("w3 data%0d", beats), ret_data_w, pat(widx(32'h30, 1, beats, 8)));
        if (beats == 0) first_n = n;
        beats++;
        if (beats == 2) begin
          resetn_w = 1'b0;
          #1;
          chk("w3 ret_valid_at_reset", 32'(ret_valid_w), 32'd0);
          chk("w3 mem_en_at_reset", 32'(mem_en_w), 32'd0);
          break;
        end
      end
    end
    chk("w3 beats_before_reset", 32'(beats), 32'd2);
`ifndef MEM_RESP_STALL_EN
    chk("w3 first_cycle", 32'(first_n), 32'd5);
`endif
    repeat (2) @(negedge clk);
    resetn_w = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk($sformatf("w3 post_reset ret_valid%0d", n), 32'(ret_valid_w), 32'd0);
      chk($sformatf("w3 post_reset rd_rdy%0d", n), 32'(rd_rdy_w), 32'd1);
      chk($sformatf("w3 post_reset mem_en%0d", n), 32'(mem_en_w), 32'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
